mdiv_unit: RTL
==============

# mdiv_unit

Parametrised iterative integer divider for the M-extension execute stage; next generation of the single-width divider. Computes DIV/DIVU/REM/REMU on WIDTH-bit operands with one quotient bit per cycle, using valid/ready handshakes on request and response. Handles RISC-V divide-by-zero and signed-overflow results in a single cycle. Carries a destination tag and supports pipeline flush.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- TAG_W, 5, width of the pass-through tag (rd index).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE and only while flush is low.
- req_op  in  2  operation, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_a  in  WIDTH  dividend.
- req_b  in  WIDTH  divisor.
- req_tag  in  TAG_W  tag, returned unchanged with the result.
- flush  in  1  synchronous abort of any in-flight operation.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  WIDTH  quotient or remainder, selected by the latched op.
- resp_tag  out  TAG_W  latched req_tag.

## Operation
- States: IDLE, CALC, DONE.
- Accept occurs on req_valid && req_ready. On accept the unit latches op, tag, operand signs, and operand magnitudes. Magnitudes are two's-complement absolute values when op[0]==0 and raw values otherwise.
- Special cases are detected in IDLE on the raw operands:
  - b==0: quotient = all ones; remainder = a.
  - Signed op with a==2^(WIDTH-1) and b==all ones: quotient = a; remainder = 0.
  - In both cases: IDLE→DONE directly and CALC is skipped.
- Normal case: IDLE→CALC with the iteration counter at 0.
- CALC is restoring division. Each cycle:
  - Compute trial = {rem, quo[MSB]} − {0, divisor}, WIDTH+1 bits.
  - If trial is non-negative, rem takes trial's low WIDTH bits; otherwise rem takes {rem, quo[MSB]}.
  - quo shifts left, inserting ~trial[WIDTH].
  - The counter increments. When counter==WIDTH−1, CALC→DONE.
- Sign fix for signed ops is applied when entering DONE:
  - The quotient is negated if the operand signs differ.
  - The remainder is negated if the dividend is negative.
- DONE: resp_valid=1. resp_data and resp_tag stay stable until resp_ready. On resp_valid && resp_ready, DONE→IDLE.
- flush (any state) → IDLE on the next edge. No response is produced, and flush overrides a coincident response handshake.
- Reset values: state IDLE; resp_valid 0; resp_data 0; resp_tag 0; counter 0. req_ready = 1 once rst deasserts (0 while rst is high).

## Timing
- Normal latency: resp_valid first rises WIDTH+1 cycles after the accept cycle, e.g. 33 cycles for WIDTH=32.
- Special-case latency: resp_valid rises in the cycle after the accept cycle.
- Throughput: req_ready rises in the cycle after the response handshake. There is no overlap between requests.
- The response outputs are registered, with no combinational path from req_* to resp_*.
- Asserting rst mid-CALC or mid-DONE clears everything immediately, and no response is produced.

## Configuration
- DIV_RESULT_CACHE_EN defined: a one-entry cache holds the last operands, signedness (op[0]), the final signed quotient, the final signed remainder, and a valid bit.
  - A request whose a, b, and op[0] match a valid entry is a hit. A hit goes IDLE→DONE with the cached quotient or remainder selected by op[1], at 1-cycle latency.
  - The cache is written when any computation, normal or special, enters DONE.
  - The cache is cleared only by rst. A flushed computation does not write it.
- DIV_RESULT_CACHE_EN undefined: no cache registers exist. Every request takes the normal or special path.

## Test plan
- DIVU 100/7 with WIDTH=32 → resp_data 14, resp_valid exactly 33 cycles after accept; REMU with the same operands → 2.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIV 7/−2 → 0xFFFFFFFD; REM 7/−2 → 1.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with 1-cycle latency; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, each with 1-cycle latency.
- Hold resp_ready low for 10 cycles in DONE → resp_valid, resp_data, and resp_tag stay stable and req_ready stays 0; raise resp_ready → req_ready is 1 on the next cycle.
- Assert flush at CALC iteration 10 → no resp_valid ever for that tag; req_ready is 1 on the next cycle; assert async rst mid-CALC → resp_valid is 0 immediately.
- With DIV_RESULT_CACHE_EN: DIV 1000/−3 (→ −333) followed by REM 1000/−3 → 1 with 1-cycle latency. Then DIVU 1000/−3 misses the cache and takes the full 33 cycles.

Source files
------------

// File: rtl/mdiv_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional one-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module mdiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [TAG_W-1:0] resp_tag
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             op_rem;
  logic [TAG_W-1:0] tag_q;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;

  // Request decode on raw operands
  logic             signed_op, a_neg, b_neg, div0, ovf;
  logic [WIDTH-1:0] a_mag, b_mag, spec_q, spec_r;

  always_comb begin
    signed_op = ~req_op[0];
    a_neg     = signed_op & req_a[WIDTH-1];
    b_neg     = signed_op & req_b[WIDTH-1];
    a_mag     = a_neg ? -req_a : req_a;
    b_mag     = b_neg ? -req_b : req_b;
    div0      = (req_b == '0);
    ovf       = signed_op && (req_a == INT_MIN) && (req_b == '1);
    spec_q    = div0 ? '1 : req_a;
    spec_r    = div0 ? req_a : '0;
  end

  // One restoring step; the final step's results also feed the sign fix
  logic [WIDTH:0]   partial, trial;
  logic [WIDTH-1:0] rem_nx, quo_nx, fin_q, fin_r;

  always_comb begin
    partial = {rem_q, quo_q[WIDTH-1]};
    trial   = partial - {1'b0, dvs_q};
    rem_nx  = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nx  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    fin_q   = neg_q ? -quo_nx : quo_nx;
    fin_r   = neg_r ? -rem_nx : rem_nx;
  end

  logic             hit;
  logic [WIDTH-1:0] hit_data;

`ifdef DIV_RESULT_CACHE_EN
  logic             c_vld, c_u, pu_q;
  logic [WIDTH-1:0] c_a, c_b, c_q, c_r, pa_q, pb_q;

  always_comb begin
    hit      = c_vld && (req_a == c_a) && (req_b == c_b) && (req_op[0] == c_u);
    hit_data = req_op[1] ? c_r : c_q;
  end
`else
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
  end
`endif

  assign req_ready = (state == IDLE) && !flush && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_rem     <= 1'b0;
      tag_q      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
`ifdef DIV_RESULT_CACHE_EN
      c_vld <= 1'b0;
      c_u   <= 1'b0;
      c_a   <= '0;
      c_b   <= '0;
      c_q   <= '0;
      c_r   <= '0;
      pu_q  <= 1'b0;
      pa_q  <= '0;
      pb_q  <= '0;
`endif
    end else if (flush) begin
      // Abort wins over everything, including a coincident response handshake
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_rem <= req_op[1];
            tag_q  <= req_tag;
            if (hit) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_data  <= hit_data;
              resp_tag   <= req_tag;
            end else if (div0 || ovf) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_data  <= req_op[1] ? spec_r : spec_q;
              resp_tag   <= req_tag;
`ifdef DIV_RESULT_CACHE_EN
              c_vld <= 1'b1;
              c_u   <= req_op[0];
              c_a   <= req_a;
              c_b   <= req_b;
              c_q   <= spec_q;
              c_r   <= spec_r;
`endif
            end else begin
              state <= CALC;
              cnt   <= '0;
              rem_q <= '0;
              quo_q <= a_mag;
              dvs_q <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
`ifdef DIV_RESULT_CACHE_EN
              pu_q <= req_op[0];
              pa_q <= req_a;
              pb_q <= req_b;
`endif
            end
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state      <= DONE;
            cnt        <= '0;
            resp_valid <= 1'b1;
            resp_data  <= op_rem ? fin_r : fin_q;
            resp_tag   <= tag_q;
`ifdef DIV_RESULT_CACHE_EN
            c_vld <= 1'b1;
            c_u   <= pu_q;
            c_a   <= pa_q;
            c_b   <= pb_q;
            c_q   <= fin_q;
            c_r   <= fin_r;
`endif
          end
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
